// File: rtl/exe_alu_stage.sv
// Execute-stage ALU with NZCV status register and EX/MEM boundary.
// Freeze holds the boundary; flush inserts a bubble.
module exe_alu_stage #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  freeze,
  input  logic                  flush,
  input  logic                  in_valid,
  input  logic [3:0]            exe_cmd,
  input  logic                  s_bit,
  input  logic [DATA_W-1:0]     val1,
  input  logic [DATA_W-1:0]     val2,
  input  logic                  wb_en_in,
  input  logic                  mem_r_en_in,
  input  logic                  mem_w_en_in,
  input  logic [REG_ADDR_W-1:0] dest_in,
  input  logic [DATA_W-1:0]     st_val_in,
  output logic                  out_valid,
  output logic [DATA_W-1:0]     alu_res,
  output logic                  wb_en,
  output logic                  mem_r_en,
  output logic                  mem_w_en,
  output logic [REG_ADDR_W-1:0] dest,
  output logic [DATA_W-1:0]     st_val,
  output logic [3:0]            status
);

  localparam logic [3:0] OP_MOV = 4'b0001;
  localparam logic [3:0] OP_MVN = 4'b1001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_ADC = 4'b0011;
  localparam logic [3:0] OP_SUB = 4'b0100;
  localparam logic [3:0] OP_SBC = 4'b0101;
  localparam logic [3:0] OP_AND = 4'b0110;
  localparam logic [3:0] OP_ORR = 4'b0111;
  localparam logic [3:0] OP_EOR = 4'b1000;

  localparam int MSB = DATA_W - 1;

  typedef struct packed {
    logic                  valid;
    logic [DATA_W-1:0]     res;
    logic                  wb;
    logic                  mr;
    logic                  mw;
    logic [REG_ADDR_W-1:0] dst;
    logic [DATA_W-1:0]     st;
  } ex_mem_t;

  ex_mem_t em_q;
  ex_mem_t em_d;

  logic              c_q;
  logic              v_q;
  logic              is_mov;
  logic              is_mvn;
  logic              is_add;
  logic              is_adc;
  logic              is_sub;
  logic              is_sbc;
  logic              is_and;
  logic              is_orr;
  logic              is_eor;
  logic              legal;
  logic              upd;
  logic              add_cin;
  logic              sub_cin;
  logic [DATA_W:0]   add_sum;
  logic [DATA_W:0]   sub_sum;
  logic [DATA_W-1:0] r;
  logic              c;
  logic              v;
  logic [3:0]        nzcv;

  assign c_q = status[1];
  assign v_q = status[0];

  assign is_mov = (exe_cmd == OP_MOV);
  assign is_mvn = (exe_cmd == OP_MVN);
  assign is_add = (exe_cmd == OP_ADD);
  assign is_adc = (exe_cmd == OP_ADC);
  assign is_sub = (exe_cmd == OP_SUB);
  assign is_sbc = (exe_cmd == OP_SBC);
  assign is_and = (exe_cmd == OP_AND);
  assign is_orr = (exe_cmd == OP_ORR);
  assign is_eor = (exe_cmd == OP_EOR);

  assign legal = is_mov | is_mvn | is_add | is_adc | is_sub
               | is_sbc | is_and | is_orr | is_eor;

  // Carry-in comes from the registered C flag, never this cycle's result.
  assign add_cin = is_adc & c_q;
  assign sub_cin = is_sbc ? c_q : 1'b1;

  // Subtraction as val1 + ~val2 + cin so carry-out is NOT borrow.
  assign add_sum = {1'b0, val1} + {1'b0, val2}
                 + {{DATA_W{1'b0}}, add_cin};
  assign sub_sum = {1'b0, val1} + {1'b0, ~val2}
                 + {{DATA_W{1'b0}}, sub_cin};

  always_comb begin
    r = '0;
    c = c_q;
    v = v_q;
    unique case (1'b1)
      is_mov: r = val2;
      is_mvn: r = ~val2;
      is_add, is_adc: begin
        r = add_sum[MSB:0];
        c = add_sum[DATA_W];
        v = (val1[MSB] == val2[MSB])
          & (r[MSB] != val1[MSB]);
      end
      is_sub, is_sbc: begin
        r = sub_sum[MSB:0];
        c = sub_sum[DATA_W];
        v = (val1[MSB] != val2[MSB])
          & (r[MSB] != val1[MSB]);
      end
      is_and: r = val1 & val2;
      is_orr: r = val1 | val2;
      is_eor: r = val1 ^ val2;
      default: begin
        r = '0;
        c = c_q;
        v = v_q;
      end
    endcase
  end

  assign nzcv = {r[MSB], (r == '0), c, v};

  assign upd = in_valid & s_bit & ~freeze
             & ~flush & legal;

  always_comb begin
    em_d       = '0;
    em_d.valid = in_valid;
    em_d.res   = r;
    em_d.wb    = wb_en_in & in_valid;
    em_d.mr    = mem_r_en_in & in_valid;
    em_d.mw    = mem_w_en_in & in_valid;
    em_d.dst   = dest_in;
    em_d.st    = st_val_in;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      em_q <= '0;
    end else if (flush) begin
      em_q <= '0;
    end else if (!freeze) begin
      em_q <= em_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      status <= 4'b0000;
    end else if (upd) begin
      status <= nzcv;
    end
  end

  assign out_valid = em_q.valid;
  assign alu_res   = em_q.res;
  assign wb_en     = em_q.wb;
  assign mem_r_en  = em_q.mr;
  assign mem_w_en  = em_q.mw;
  assign dest      = em_q.dst;
  assign st_val    = em_q.st;

endmodule

// File: doc/exe_alu_stage.md
Name: exe_alu_stage

Overview:
Execute-stage ALU that consumes Val1 (Rn) and the operand-2 value from the Val2 generator. It computes the data-processing result and maintains the registered NZCV status register. It drives the registered EX/MEM pipeline boundary (result, control, destination, store data) toward the memory stage, with freeze and flush support for hazard and branch handling.

Parameters:
DATA_W, 32, datapath width for val1/val2/result/store data
REG_ADDR_W, 4, register-file index width

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset
freeze  input  1  hazard stall; hold all registered state
flush  input  1  branch flush; insert bubble at EX/MEM
in_valid  input  1  EX-stage instruction valid
exe_cmd  input  4  ALU opcode
s_bit  input  1  instruction requests status update
val1  input  DATA_W  first operand (Rn)
val2  input  DATA_W  second operand from Val2 generator
wb_en_in  input  1  writeback enable from ID/EX
mem_r_en_in  input  1  load enable from ID/EX
mem_w_en_in  input  1  store enable from ID/EX
dest_in  input  REG_ADDR_W  destination register
st_val_in  input  DATA_W  store data (Rm value)
out_valid  output  1  EX/MEM entry valid
alu_res  output  DATA_W  registered ALU result / memory address
wb_en  output  1  registered writeback enable
mem_r_en  output  1  registered load enable
mem_w_en  output  1  registered store enable
dest  output  REG_ADDR_W  registered destination
st_val  output  DATA_W  registered store data
status  output  4  registered {N,Z,C,V}, read by ID condition check

Behaviour:
- All state updates on rising clk. rst_n=0 at an edge clears every output and status to 0, including mid-freeze or mid-flush.
- Opcodes (combinational result r, carry c, overflow v):
  - 0001 MOV r=val2
  - 1001 MVN r=~val2
  - 0010 ADD r=val1+val2
  - 0011 ADC r=val1+val2+C
  - 0100 SUB r=val1-val2
  - 0101 SBC r=val1-val2-(~C)
  - 0110 AND
  - 0111 ORR
  - 1000 EOR
  - CMP and TST reuse 0100/0110 with wb_en_in=0. LDR/STR use 0010 (address = val1+val2).
  - Any other code: r=0, no status update.
- Arithmetic width rules:
  - Add: DATA_W+1-bit sum; c = bit DATA_W.
  - Sub: c = NOT borrow (1 when val1 >= val2 + borrow-in, unsigned).
  - Add V: operand signs equal and result sign differs.
  - Sub V: val1/val2 signs differ and result sign differs from val1.
  - Logic and MOV/MVN: c and v take the current status C and V (preserved).
- C used by ADC/SBC is the registered status C, not this cycle's c.
- N = r[DATA_W-1]. Z = (r==0).
- Status write at an edge iff in_valid & s_bit & !freeze & !flush & opcode legal. Otherwise status holds. Back-to-back flag-setting ops: the second sees the first's flags one cycle later, with no bypass.
- Pipeline register priority per edge: reset > flush > freeze > load.
  - flush: out_valid, wb_en, mem_r_en, mem_w_en go to 0. alu_res, dest, st_val go to 0.
  - freeze (no flush): every output holds.
  - load: out_valid<=in_valid. Control bits <= *_in & in_valid. alu_res<=r, dest<=dest_in, st_val<=st_val_in.
- Latency: one cycle from inputs to registered outputs and status.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with random inputs -> all outputs and status=0000. Release -> first valid ADD appears one cycle later.
- ADD overflow: val1=0x7FFFFFFF, val2=1, exe_cmd=0010, s_bit=1 -> alu_res=0x80000000, status=1001 (N=1, V=1).
- SUB/CMP: val1=5, val2=5, cmd 0100, s_bit=1, wb_en_in=0 -> status=0110, wb_en=0. Then val1=3, val2=5 -> alu_res=0xFFFFFFFE, status=1000.
- ADC chain: ADD 0xFFFFFFFF+1 with S (C=1). Next cycle ADC 2+3 without S -> alu_res=6, status unchanged 0110.
- Freeze/flush: freeze=1 for 3 cycles with changing inputs -> outputs and status hold. Assert flush=1 together with freeze=1 and s_bit=1 -> out_valid=0, wb_en=0, status unchanged.
- Logic preservation: status C=1, V=1, then AND 0xF0 & 0x0F with S -> alu_res=0, status=0111.
